operand_loader: RTL and testbench

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/loader_pkg.sv | 17 +
 rtl/btn_debouncer.sv | 68 ++++++
 rtl/operand_loader.sv | 118 +++++++++++
 tb/tb_operand_loader.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the operand loader.
//   state_e            : loader FSM states, encoding is driven directly on stage
//   SEL_W              : width of the ALU operation code
//   DEBOUNCE_DEFAULT   : debounce window in clk cycles (1 ms at 50 MHz)
package loader_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        SHOW    = 2'b11
    } state_e;

    localparam int SEL_W            = 3;
    localparam int DEBOUNCE_DEFAULT = 50000;

endpackage

// File: rtl/btn_debouncer.sv
// Two-flop synchronizer, debouncer and rising-edge detector for one push-button.
//   clk     : system clock
//   rst     : synchronous active-high reset
//   btn_i   : raw, bouncing, asynchronous button level
//   pulse_o : one-cycle pulse on an accepted press
module btn_debouncer
    import loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             sync1_q, sync2_q;
    logic [1:0]       fill_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             edge_q;
    logic             armed_q, armed_d;

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q >= CNT_TC) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
        // Pulses are only allowed once the synchronized button has been seen
        // released after reset; a button held through reset stays silent.
        armed_d = armed_q | (fill_q[1] & ~sync2_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            fill_q  <= 2'b00;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            edge_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            fill_q  <= {fill_q[0], 1'b1};
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            edge_q  <= deb_q;
            armed_q <= armed_d;
        end
    end

    assign pulse_o = deb_q & ~edge_q & armed_q;

endmodule

// File: rtl/operand_loader.sv
// Loads two operands and an ALU operation code from slide switches, one per
// debounced enter press, then presents them with valid until the next press.
//   clk, rst   : system clock, synchronous active-high reset
//   switches   : raw switch value (asynchronous)
//   enter_btn  : raw bouncing enter button
//   clear_btn  : raw clear button, level-sensitive, wins over enter
//   A, B       : registered operands
//   select     : registered operation code
//   valid      : high while in SHOW
//   stage      : current state encoding
//
// state   | meaning
// LOAD_A  | waiting for operand A
// LOAD_B  | waiting for operand B
// LOAD_OP | waiting for operation code
// SHOW    | complete operand set presented
module operand_loader
    import loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int DATA_W          = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] switches,
    input  logic              enter_btn,
    input  logic              clear_btn,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [SEL_W-1:0]  select,
    output logic              valid,
    output logic [1:0]        stage
);

    logic [DATA_W-1:0] sw_s1_q, sw_s2_q;
    logic              clr_s1_q, clr_s2_q;
    logic              enter_pulse;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              valid_q, valid_d;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_enter_deb (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (enter_btn),
        .pulse_o(enter_pulse)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        if (clr_s2_q) begin
            state_d = LOAD_A;
            a_d     = '0;
            b_d     = '0;
            sel_d   = '0;
        end else if (enter_pulse) begin
            case (state_q)
                LOAD_A: begin
                    a_d     = sw_s2_q;
                    state_d = LOAD_B;
                end
                LOAD_B: begin
                    b_d     = sw_s2_q;
                    state_d = LOAD_OP;
                end
                LOAD_OP: begin
                    sel_d   = sw_s2_q[SEL_W-1:0];
                    state_d = SHOW;
                end
                SHOW: begin
                    state_d = LOAD_A;
                end
                default: begin
                    state_d = LOAD_A;
                end
            endcase
        end
        valid_d = (state_d == SHOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            clr_s1_q <= 1'b0;
            clr_s2_q <= 1'b0;
            state_q  <= LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            sw_s1_q  <= switches;
            sw_s2_q  <= sw_s1_q;
            clr_s1_q <= clear_btn;
            clr_s2_q <= clr_s1_q;
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
        end
    end

    assign A      = a_q;
    assign B      = b_q;
    assign select = sel_q;
    assign valid  = valid_q;
    assign stage  = state_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with DEBOUNCE_CYCLES=4, DATA_W=4.
// Outputs are compared as one packed word {A, B, select, valid, stage}.
module tb_operand_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] switches;
    logic       enter_btn;
    logic       clear_btn;
    logic [3:0] A, B;
    logic [2:0] select;
    logic       valid;
    logic [1:0] stage;

    int passed = 0;
    int total  = 0;
    logic [13:0] cur;

    typedef struct {
        logic [3:0]  sw;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[8];

    operand_loader #(
        .DEBOUNCE_CYCLES(4),
        .DATA_W         (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .switches (switches),
        .enter_btn(enter_btn),
        .clear_btn(clear_btn),
        .A        (A),
        .B        (B),
        .select   (select),
        .valid    (valid),
        .stage    (stage)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] pk(input logic [3:0] a, input logic [3:0] b,
                                       input logic [2:0] s, input logic v,
                                       input logic [1:0] st);
        return {a, b, s, v, st};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [13:0] exp);
        logic [13:0] act;
        act = {A, B, select, valid, stage};
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got A=%h B=%h sel=%h valid=%b stage=%h, expected A=%h B=%h sel=%h valid=%b stage=%h",
                     name, act[13:10], act[9:6], act[5:3], act[2], act[1:0],
                     exp[13:10], exp[9:6], exp[5:3], exp[2], exp[1:0]);
        end
    endtask

    // Clean press: capture must land exactly 7 edges after the raw rise,
    // and holding the button must not produce a second capture.
    task automatic press(input logic [3:0] sw, input logic [13:0] exp, input string name);
        switches = sw;
        repeat (4) tick();
        check($sformatf("%s_motion", name), cur);
        enter_btn = 1'b1;
        repeat (6) tick();
        check($sformatf("%s_pre", name), cur);
        tick();
        check($sformatf("%s_cap", name), exp);
        cur = exp;
        repeat (3) tick();
        check($sformatf("%s_hold", name), cur);
        enter_btn = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        vecs[0] = '{4'b0101, pk(4'h5, 4'h0, 3'd0, 1'b0, 2'd1)};
        vecs[1] = '{4'b0111, pk(4'h5, 4'h7, 3'd0, 1'b0, 2'd2)};
        vecs[2] = '{4'b1001, pk(4'h5, 4'h7, 3'd1, 1'b1, 2'd3)};
        vecs[3] = '{4'b0000, pk(4'h5, 4'h7, 3'd1, 1'b0, 2'd0)};
        vecs[4] = '{4'b0011, pk(4'h3, 4'h7, 3'd1, 1'b0, 2'd1)};
        vecs[5] = '{4'b1010, pk(4'h3, 4'hA, 3'd1, 1'b0, 2'd2)};
        vecs[6] = '{4'b0110, pk(4'h3, 4'hA, 3'd6, 1'b1, 2'd3)};
        vecs[7] = '{4'b1111, pk(4'h3, 4'hA, 3'd6, 1'b0, 2'd0)};

        rst       = 1'b1;
        switches  = 4'b1011;
        enter_btn = 1'b0;
        clear_btn = 1'b0;
        repeat (3) tick();
        cur = pk(4'h0, 4'h0, 3'd0, 1'b0, 2'd0);
        check("reset_state", cur);
        rst = 1'b0;
        repeat (2) tick();
        check("after_reset", cur);

        for (int i = 0; i < 8; i++) begin
            press(vecs[i].sw, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Bounce 1-0-1 at 2-cycle intervals, then held.
        switches = 4'b1001;
        repeat (4) tick();
        enter_btn = 1'b1;
        repeat (2) tick();
        enter_btn = 1'b0;
        repeat (2) tick();
        enter_btn = 1'b1;
        repeat (6) tick();
        check("bounce_pre", cur);
        tick();
        cur = pk(4'h9, 4'hA, 3'd6, 1'b0, 2'd1);
        check("bounce_cap", cur);
        repeat (5) tick();
        check("bounce_single", cur);
        enter_btn = 1'b0;
        repeat (10) tick();

        press(4'b0100, pk(4'h9, 4'h4, 3'd6, 1'b0, 2'd2), "ldb");

        // Clear reaches the FSM in the same cycle as the enter pulse.
        switches = 4'b0111;
        repeat (4) tick();
        enter_btn = 1'b1;
        repeat (4) tick();
        clear_btn = 1'b1;
        tick();
        clear_btn = 1'b0;
        tick();
        check("clear_pre", cur);
        tick();
        cur = pk(4'h0, 4'h0, 3'd0, 1'b0, 2'd0);
        check("clear_cap", cur);
        repeat (8) tick();
        check("clear_nocap", cur);
        enter_btn = 1'b0;
        repeat (10) tick();

        // Reset in SHOW with enter held through it.
        press(4'b0001, pk(4'h1, 4'h0, 3'd0, 1'b0, 2'd1), "rs_a");
        press(4'b0010, pk(4'h1, 4'h2, 3'd0, 1'b0, 2'd2), "rs_b");
        press(4'b0101, pk(4'h1, 4'h2, 3'd5, 1'b1, 2'd3), "rs_op");
        switches = 4'b1111;
        repeat (4) tick();
        enter_btn = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cur = pk(4'h0, 4'h0, 3'd0, 1'b0, 2'd0);
        check("rst_show", cur);
        repeat (20) tick();
        check("rst_held", cur);
        enter_btn = 1'b0;
        repeat (10) tick();
        press(4'b1100, pk(4'hC, 4'h0, 3'd0, 1'b0, 2'd1), "repress");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
